// File: rtl/jtag_pkg.sv
// jtag_pkg: shared TAP state encodings and IR capture constants for the JTAG slice.
package jtag_pkg;

   typedef enum logic [3:0] {
      EXIT2_DR = 4'h0,
      EXIT1_DR = 4'h1,
      SHIFT_DR = 4'h2,
      PAUSE_DR = 4'h3,
      SEL_IR   = 4'h4,
      UPD_DR   = 4'h5,
      CAP_DR   = 4'h6,
      SEL_DR   = 4'h7,
      EXIT2_IR = 4'h8,
      EXIT1_IR = 4'h9,
      SHIFT_IR = 4'hA,
      PAUSE_IR = 4'hB,
      RTI      = 4'hC,
      UPD_IR   = 4'hD,
      CAP_IR   = 4'hE,
      TLR      = 4'hF
   } tap_state_t;

   localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

   function automatic logic isShift(input tap_state_t s);
      return (s == SHIFT_IR) || (s == SHIFT_DR);
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state IEEE 1149.1 TAP controller, advanced by TMS on rising TCLK.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       TCLK,
   input  logic       TRESETN,
   input  logic       TMS,
   output tap_state_t state
);

   tap_state_t nextState;

   always_ff @(posedge TCLK or negedge TRESETN)
      if (!TRESETN) state <= TLR;
      else          state <= nextState;

   always_comb begin
      nextState = state;
      unique case (state)
         TLR:      nextState = TMS ? TLR      : RTI;
         RTI:      nextState = TMS ? SEL_DR   : RTI;
         SEL_DR:   nextState = TMS ? SEL_IR   : CAP_DR;
         SEL_IR:   nextState = TMS ? TLR      : CAP_IR;
         CAP_DR:   nextState = TMS ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: nextState = TMS ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: nextState = TMS ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: nextState = TMS ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: nextState = TMS ? UPD_DR   : SHIFT_DR;
         UPD_DR:   nextState = TMS ? SEL_DR   : RTI;
         CAP_IR:   nextState = TMS ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: nextState = TMS ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: nextState = TMS ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: nextState = TMS ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: nextState = TMS ? UPD_IR   : SHIFT_IR;
         UPD_IR:   nextState = TMS ? SEL_DR   : RTI;
         default:  nextState = TLR;
      endcase
   end

endmodule

// File: rtl/jtag_tap_ir.sv
// jtag_tap_ir: TAP controller with integrated instruction register and falling-edge TDO.
// Define JTAG_IR_CAPTURE_STATUS_EN to capture status_in into the upper IR bits on CAPTURE_IR.
module jtag_tap_ir
   import jtag_pkg::*;
#(
   parameter int              IR_W     = 8,
   parameter logic [IR_W-1:0] IR_RESET = '1
) (
   input  logic            TCLK,
   input  logic            TRESETN,
   input  logic            TMS,
   input  logic            TDI,
   input  logic            dr_tdo,
   input  logic [IR_W-3:0] status_in,
   output logic            TDO,
   output logic            TDO_EN,
   output logic [IR_W-1:0] ir_out,
   output logic [3:0]      tap_state,
   output logic            capture_dr,
   output logic            shift_dr,
   output logic            update_dr,
   output logic            tlr
);

   tap_state_t      state;
   logic [IR_W-1:0] irShift;
   logic [IR_W-1:0] captureVal;

   jtag_tap_fsm uFsm (
      .TCLK    (TCLK),
      .TRESETN (TRESETN),
      .TMS     (TMS),
      .state   (state)
   );

`ifdef JTAG_IR_CAPTURE_STATUS_EN
   assign captureVal = IR_W'({status_in, IR_CAPTURE_LSBS});
`else
   // status_in is deliberately masked so a tied-off port costs nothing
   assign captureVal = IR_W'({status_in & '0, IR_CAPTURE_LSBS});
`endif

   always_ff @(posedge TCLK or negedge TRESETN)
      if (!TRESETN)               irShift <= '0;
      else if (state == CAP_IR)   irShift <= captureVal;
      else if (state == SHIFT_IR) irShift <= {TDI, irShift[IR_W-1:1]};

   // Falling-edge retime keeps TDO stable across the host's rising-edge sample
   always_ff @(negedge TCLK or negedge TRESETN)
      if (!TRESETN) begin
         ir_out <= IR_RESET;
         TDO    <= 1'b0;
         TDO_EN <= 1'b0;
      end else begin
         ir_out <= (state == UPD_IR) ? irShift : (state == TLR) ? IR_RESET : ir_out;
         TDO    <= (state == SHIFT_IR) ? irShift[0] : (state == SHIFT_DR) ? dr_tdo : 1'b0;
         TDO_EN <= isShift(state);
      end

   assign tap_state  = state;
   assign capture_dr = state == CAP_DR;
   assign shift_dr   = state == SHIFT_DR;
   assign update_dr  = state == UPD_DR;
   assign tlr        = state == TLR;

endmodule

// File: tb/tb_jtag_tap_ir.sv
// tb_jtag_tap_ir: directed and randomized checks of jtag_tap_ir against a table-driven model.
module tb_jtag_tap_ir;

   logic       TCLK = 1'b0;
   logic       TRESETN = 1'b1;
   logic       TMS = 1'b1, TDI = 1'b0, dr_tdo = 1'b0;
   logic [5:0] status_in = 6'h0;
   logic       TDO, TDO_EN, capture_dr, shift_dr, update_dr, tlr;
   logic [7:0] ir_out;
   logic [3:0] tap_state;

   int total = 0, bad = 0;

   // Transition tables indexed by the 1149.1 state code: next state for TMS=0 / TMS=1
   logic [3:0] n0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                           4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
   logic [3:0] n1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                           4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

   logic [3:0] ms;
   logic [7:0] mIr, mOut;
   logic       mTdo, mEn;

   jtag_tap_ir #(.IR_W(8)) dut (
      .TCLK       (TCLK),
      .TRESETN    (TRESETN),
      .TMS        (TMS),
      .TDI        (TDI),
      .dr_tdo     (dr_tdo),
      .status_in  (status_in),
      .TDO        (TDO),
      .TDO_EN     (TDO_EN),
      .ir_out     (ir_out),
      .tap_state  (tap_state),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .tlr        (tlr)
   );

   always #5 TCLK = ~TCLK;

   function automatic logic [7:0] capExp(input logic [5:0] st);
`ifdef JTAG_IR_CAPTURE_STATUS_EN
      return {st, 2'b01};
`else
      return 8'h01;
`endif
   endfunction

   task automatic modelReset();
      ms = 4'hF; mIr = 8'h00; mOut = 8'hFF; mTdo = 1'b0; mEn = 1'b0;
   endtask

   // One TCK cycle: inputs change just after the falling edge, outputs observed 1 time unit later
   task automatic step(input logic tms, input logic tdi, input logic drt);
      TMS = tms; TDI = tdi; dr_tdo = drt;
      @(posedge TCLK);
      if (ms == 4'hE) mIr = capExp(status_in);
      else if (ms == 4'hA) mIr = {tdi, mIr[7:1]};
      ms = tms ? n1[ms] : n0[ms];
      @(negedge TCLK);
      if (ms == 4'hD) mOut = mIr;
      else if (ms == 4'hF) mOut = 8'hFF;
      mEn  = (ms == 4'hA) || (ms == 4'h2);
      mTdo = (ms == 4'hA) ? mIr[0] : (ms == 4'h2) ? drt : 1'b0;
      #1;
   endtask

   task automatic goRti();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      TRESETN = 1'b0;
      modelReset();
      #2;
      total++; if (tap_state !== 4'hF) begin bad++; $display("FAIL reset_state got=%h exp=f", tap_state); end
      total++; if (ir_out !== 8'hFF) begin bad++; $display("FAIL reset_ir got=%h exp=ff", ir_out); end
      total++; if ({TDO, TDO_EN} !== 2'b00) begin bad++; $display("FAIL reset_tdo got=%b exp=00", {TDO, TDO_EN}); end
      total++; if ({tlr, capture_dr, shift_dr, update_dr} !== 4'b1000) begin bad++; $display("FAIL reset_strobes got=%b exp=1000", {tlr, capture_dr, shift_dr, update_dr}); end
      @(negedge TCLK); #1;
      TRESETN = 1'b1;
   endtask

   task automatic test_ir_scan(input logic [7:0] v);
      logic [7:0] got;
      status_in = 6'h2A;
      step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
      got[0] = TDO;
      total++; if (TDO_EN !== 1'b1) begin bad++; $display("FAIL scan_tdo_en got=%b exp=1", TDO_EN); end
      for (int i = 0; i < 8; i++) begin
         step(i == 7, v[i], 1'b0);
         if (i < 7) got[i+1] = TDO;
      end
      total++; if (got !== capExp(6'h2A)) begin bad++; $display("FAIL scan_capture got=%h exp=%h", got, capExp(6'h2A)); end
      total++; if ({tap_state, TDO_EN} !== {4'h9, 1'b0}) begin bad++; $display("FAIL scan_exit1 got=%h/%b exp=9/0", tap_state, TDO_EN); end
      step(1'b1, 1'b0, 1'b0);
      total++; if (ir_out !== v) begin bad++; $display("FAIL scan_update got=%h exp=%h", ir_out, v); end
      step(1'b0, 1'b0, 1'b0);
      total++; if (tap_state !== 4'hC) begin bad++; $display("FAIL scan_rti got=%h exp=c", tap_state); end
   endtask

   task automatic test_tlr_from_pause_dr();
      step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
      total++; if (tap_state !== 4'h3) begin bad++; $display("FAIL tlr_pause_dr got=%h exp=3", tap_state); end
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
      total++; if (tlr !== 1'b0) begin bad++; $display("FAIL tlr_early got=%b exp=0", tlr); end
      step(1'b1, 1'b0, 1'b0);
      total++; if (tlr !== 1'b1) begin bad++; $display("FAIL tlr_reached got=%b exp=1", tlr); end
      total++; if (ir_out !== 8'hFF) begin bad++; $display("FAIL tlr_ir got=%h exp=ff", ir_out); end
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_pause_ir();
      logic [7:0] v = 8'h3C;
      step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(i == 3, v[i], 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0);
         total++; if (tap_state !== 4'hB) begin bad++; $display("FAIL pause_state got=%h exp=b", tap_state); end
      end
      step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
      total++; if (tap_state !== 4'hA) begin bad++; $display("FAIL pause_resume got=%h exp=a", tap_state); end
      for (int i = 4; i < 8; i++) step(i == 7, v[i], 1'b0);
      step(1'b1, 1'b0, 1'b0);
      total++; if (ir_out !== 8'h3C) begin bad++; $display("FAIL pause_update got=%h exp=3c", ir_out); end
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_shift();
      step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
      total++; if (TDO_EN !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b exp=1", TDO_EN); end
      TRESETN = 1'b0;
      modelReset();
      #1;
      total++; if (tap_state !== 4'hF) begin bad++; $display("FAIL midrst_state got=%h exp=f", tap_state); end
      total++; if (ir_out !== 8'hFF) begin bad++; $display("FAIL midrst_ir got=%h exp=ff", ir_out); end
      total++; if ({TDO, TDO_EN, tlr} !== 3'b001) begin bad++; $display("FAIL midrst_out got=%b exp=001", {TDO, TDO_EN, tlr}); end
      #1;
      TRESETN = 1'b1;
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_dr_path();
      logic tq [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int capCnt = 0, updCnt = 0;
      logic drt;
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         drt = 1'($urandom);
         step(tq[i], 1'b0, drt);
         capCnt += int'(capture_dr);
         updCnt += int'(update_dr);
         total++; if (shift_dr !== (i >= 1 && i <= 5)) begin bad++; $display("FAIL dr_shift i=%0d got=%b", i, shift_dr); end
         total++; if (TDO !== ((i >= 1 && i <= 5) ? drt : 1'b0)) begin bad++; $display("FAIL dr_tdo i=%0d got=%b exp=%b", i, TDO, (i >= 1 && i <= 5) ? drt : 1'b0); end
      end
      total++; if (capCnt != 1) begin bad++; $display("FAIL dr_capture_cycles got=%0d exp=1", capCnt); end
      total++; if (updCnt != 1) begin bad++; $display("FAIL dr_update_cycles got=%0d exp=1", updCnt); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         status_in = 6'($urandom);
         step(($urandom_range(0, 9) < 4), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 99) == 0) begin
            TRESETN = 1'b0; modelReset(); #1; TRESETN = 1'b1;
         end
         total++; if (tap_state !== ms) begin bad++; $display("FAIL rnd_state i=%0d got=%h exp=%h", i, tap_state, ms); end
         total++; if (ir_out !== mOut) begin bad++; $display("FAIL rnd_ir i=%0d got=%h exp=%h", i, ir_out, mOut); end
         total++; if (TDO !== mTdo) begin bad++; $display("FAIL rnd_tdo i=%0d got=%b exp=%b", i, TDO, mTdo); end
         total++; if (TDO_EN !== mEn) begin bad++; $display("FAIL rnd_tdo_en i=%0d got=%b exp=%b", i, TDO_EN, mEn); end
         total++; if (capture_dr !== (ms == 4'h6)) begin bad++; $display("FAIL rnd_cap i=%0d got=%b", i, capture_dr); end
         total++; if (shift_dr !== (ms == 4'h2)) begin bad++; $display("FAIL rnd_shift i=%0d got=%b", i, shift_dr); end
         total++; if (update_dr !== (ms == 4'h5)) begin bad++; $display("FAIL rnd_upd i=%0d got=%b", i, update_dr); end
         total++; if (tlr !== (ms == 4'hF)) begin bad++; $display("FAIL rnd_tlr i=%0d got=%b", i, tlr); end
      end
   endtask

   initial begin
      #1;
      test_reset();
      goRti();
      test_ir_scan(8'hA5);
      test_tlr_from_pause_dr();
      test_pause_ir();
      test_reset_mid_shift();
      test_dr_path();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jtag_tap_ir.md
# jtag_tap_ir

Parametrised JTAG TAP controller with integrated instruction register. Implements the 16-state IEEE 1149.1 TAP state machine driven by TMS, and an IR_W-bit instruction register with capture/shift/update semantics and a falling-edge TDO path. It supplies the decoded instruction and the DR-side control strobes (capture/shift/update) to the test data registers downstream.

## Interface
Parameters:
- IR_W, 8: instruction register width, legal range 2..32.
- IR_RESET, all ones (BYPASS): instruction loaded on reset and in TEST_LOGIC_RESET.

Ports:
- TCLK  in  1  test clock.
- TRESETN  in  1  asynchronous, active-low reset.
- TMS  in  1  mode select, sampled on rising TCLK.
- TDI  in  1  serial data in, sampled on rising TCLK.
- dr_tdo  in  1  serial out of the currently selected DR.
- status_in  in  IR_W-2  capture status (used only with the configuration macro).
- TDO  out  1  serial data out, changes on falling TCLK.
- TDO_EN  out  1  high while in SHIFT_IR or SHIFT_DR, changes on falling TCLK.
- ir_out  out  IR_W  current instruction.
- tap_state  out  4  current TAP state encoding.
- capture_dr, shift_dr, update_dr  out  1 each  high while in the corresponding state.
- tlr  out  1  high while in TEST_LOGIC_RESET.

## Operation
- Reset (TRESETN low, async): tap_state = TEST_LOGIC_RESET, ir_shift = 0, ir_out = IR_RESET, TDO = 0, TDO_EN = 0, tlr = 1, all DR strobes 0.
- FSM state register updates on rising TCLK. Transitions are (TMS=0 / TMS=1):
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - SEL_IR: CAP_IR / TLR
  - CAP_x: SHIFT_x / EXIT1_x
  - SHIFT_x: SHIFT_x / EXIT1_x
  - EXIT1_x: PAUSE_x / UPD_x
  - PAUSE_x: PAUSE_x / EXIT2_x
  - EXIT2_x: SHIFT_x / UPD_x
  - UPD_x: RTI / SEL_DR
- Five consecutive TMS=1 rising edges reach TLR from any state.
- IR shift register, rising TCLK:
  - In CAP_IR, load {capture_hi, 2'b01}, where capture_hi = 0 by default.
  - In SHIFT_IR, shift right with TDI into bit IR_W-1.
  - Otherwise hold.
- ir_out, falling TCLK:
  - In UPD_IR, load ir_shift.
  - In TLR, load IR_RESET.
  - Otherwise hold.
- TDO / TDO_EN, falling TCLK:
  - SHIFT_IR: TDO = ir_shift[0], TDO_EN = 1.
  - SHIFT_DR: TDO = dr_tdo, TDO_EN = 1.
  - Otherwise: TDO = 0, TDO_EN = 0.
- DR strobes and tlr are decoded directly from the state register (no extra latency). The block shifts no DR data itself.
- Boundary conditions:
  - TRESETN asserted mid-shift aborts the shift. Partial IR contents are discarded and ir_out returns to IR_RESET.
  - PAUSE_IR/EXIT2_IR preserve ir_shift, so resuming SHIFT_IR continues the same scan.
  - Leaving via EXIT1_IR → UPD_IR after N shifts with N < IR_W updates with a partially shifted value. This is legal by design.

## Timing
- TMS/TDI are sampled on rising TCLK.
- TDO is valid from falling TCLK and is sampled by the host on the next rising edge.
- First captured bit (1, LSB of 01) appears on TDO at the falling edge in the first SHIFT_IR cycle.
- An IR scan of IR_W bits from RTI takes these TMS values: 1,1,0,0 then IR_W-1 zeros then 1 (last bit in EXIT1), then 1 (UPD), 0 (RTI).
- ir_out changes at the falling edge during UPD_IR, half a cycle before leaving UPD_IR.

## Configuration
- JTAG_IR_CAPTURE_STATUS_EN defined:
  - CAP_IR loads {status_in, 2'b01}.
  - status_in is sampled on that rising edge.
- Not defined:
  - CAP_IR loads {(IR_W-2)'b0, 2'b01}.
  - status_in is ignored and may be tied off.

## Structure
- Package jtag_pkg:
  - tap_state_t enum with the standard 1149.1 4-bit encodings (TLR=4'hF, RTI=4'hC, SEL_DR=4'h7, CAP_DR=4'h6, SHIFT_DR=4'h2, EXIT1_DR=4'h1, PAUSE_DR=4'h3, EXIT2_DR=4'h0, UPD_DR=4'h5, SEL_IR=4'h4, CAP_IR=4'hE, SHIFT_IR=4'hA, EXIT1_IR=4'h9, PAUSE_IR=4'hB, EXIT2_IR=4'h8, UPD_IR=4'hD).
  - IR_CAPTURE_LSBS = 2'b01.
- Sub-module jtag_tap_fsm: TMS-driven state register and next-state logic, outputs tap_state.
- Top level: IR shift/update registers, TDO mux/retime, strobe decode.

## Test plan
- TRESETN pulse low mid-SHIFT_IR → tap_state=4'hF, ir_out=IR_RESET (8'hFF), TDO=0, TDO_EN=0 immediately.
- From arbitrary state (e.g. PAUSE_DR), five TMS=1 clocks → tlr=1; ir_out forced to 8'hFF at next falling edge.
- IR_W=8 scan shifting 8'hA5 LSB-first → TDO emits 1,0,0,0,0,0,0,0 (capture 8'h01); ir_out=8'hA5 after UPD_IR falling edge.
- Scan 4 bits, PAUSE_IR for 3 clocks, resume 4 bits of 8'h3C → ir_out=8'h3C; no bits lost or duplicated.
- DR path: navigate to SHIFT_DR with dr_tdo toggling → shift_dr=1 each cycle, TDO follows dr_tdo delayed to falling edge, capture_dr/update_dr each high exactly one cycle.
- With JTAG_IR_CAPTURE_STATUS_EN, status_in=6'h2A → first 8 TDO bits are 1,0,0,1,0,1,0,1 (8'hA9 LSB-first); without the macro → 1 followed by seven 0.
